// File: rtl/hwpe_tcdm_rr_arbiter.sv
// hwpe_tcdm_rr_arbiter: round-robin sharing of one TCDM port among NB_REQ requesters, with in-order response routing
module hwpe_tcdm_rr_arbiter #(
    parameter int unsigned NB_REQ          = 3,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NB_REQ-1:0]                    in_req,
    output logic [NB_REQ-1:0]                    in_gnt,
    input  logic [NB_REQ*ADDR_WIDTH-1:0]         in_add,
    input  logic [NB_REQ-1:0]                    in_wen,
    input  logic [NB_REQ*DATA_WIDTH/8-1:0]       in_be,
    input  logic [NB_REQ*DATA_WIDTH-1:0]         in_data,
    output logic [NB_REQ*DATA_WIDTH-1:0]         in_r_data,
    output logic [NB_REQ-1:0]                    in_r_valid,
    output logic                                 out_req,
    input  logic                                 out_gnt,
    output logic [ADDR_WIDTH-1:0]                out_add,
    output logic                                 out_wen,
    output logic [DATA_WIDTH/8-1:0]              out_be,
    output logic [DATA_WIDTH-1:0]                out_data,
    input  logic [DATA_WIDTH-1:0]                out_r_data,
    input  logic                                 out_r_valid,
    output logic [$clog2(MAX_OUTSTANDING):0]     outstanding_o,
    output logic                                 err_o
);
    localparam int unsigned PW = $clog2(NB_REQ);
    localparam int unsigned AW = $clog2(MAX_OUTSTANDING);
    localparam int unsigned BW = DATA_WIDTH / 8;

    logic [PW-1:0] ptr, sel, head;
    logic [PW-1:0] fifo_q [MAX_OUTSTANDING];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt;
    logic          any, full, empty, push, pop;

    // scan from the highest rotated offset down so the one nearest ptr wins
    always_comb begin
        sel = '0;
        for (int i = NB_REQ - 1; i >= 0; i--) begin
            if (in_req[(int'(ptr) + i) % NB_REQ]) sel = PW'((int'(ptr) + i) % NB_REQ);
        end
    end

    assign any   = |in_req;
    assign full  = cnt == (AW+1)'(MAX_OUTSTANDING);
    assign empty = cnt == '0;
    assign head  = fifo_q[rd_ptr];

    assign out_req  = rst_ni && any && !full;
    assign out_add  = any ? in_add[sel*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign out_wen  = any && in_wen[sel];
    assign out_be   = any ? in_be[sel*BW +: BW] : '0;
    assign out_data = any ? in_data[sel*DATA_WIDTH +: DATA_WIDTH] : '0;

    assign push       = out_req && out_gnt;
    assign pop        = out_r_valid && !empty;
    assign in_gnt     = push ? NB_REQ'(1) << sel : '0;
    assign in_r_valid = pop ? NB_REQ'(1) << head : '0;
    assign in_r_data  = {NB_REQ{out_r_data}};
    assign outstanding_o = cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            err_o  <= 1'b0;
        end else begin
            if (push) begin
                ptr    <= (sel == PW'(NB_REQ - 1)) ? '0 : sel + 1'b1;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            if (out_r_valid && empty) err_o <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wr_ptr] <= sel;
    end
endmodule

// File: doc/hwpe_tcdm_rr_arbiter.md
Name: hwpe_tcdm_rr_arbiter

Overview:
- Shares one TCDM master port between NB_REQ HWPE-side TCDM requesters (e.g. operand streamers and result streamer) using round-robin arbitration.
- Routes each in-order response (r_valid/r_data) back to the requester that issued the matching request.
- A routing FIFO tracks outstanding requests.
- Sits between the streamer TCDM ports and the flat tcdm_* ports of the top-level wrapper, so an engine can run with fewer physical TCDM ports than logical streams.

Parameters:
- NB_REQ, 3, number of requester ports (≥2).
- MAX_OUTSTANDING, 4, routing FIFO depth, i.e. maximum granted-but-unanswered transactions (power of 2, ≥2).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; BE width = DATA_WIDTH/8.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- in_req  in  NB_REQ  requester request.
- in_gnt  out  NB_REQ  requester grant.
- in_add  in  NB_REQ×ADDR_WIDTH  requester address.
- in_wen  in  NB_REQ  1 = read, 0 = write.
- in_be  in  NB_REQ×DATA_WIDTH/8  byte enables.
- in_data  in  NB_REQ×DATA_WIDTH  write data.
- in_r_data  out  NB_REQ×DATA_WIDTH  response data.
- in_r_valid  out  NB_REQ  response valid.
- out_req  out  1  TCDM request.
- out_gnt  in  1  TCDM grant.
- out_add  out  ADDR_WIDTH  TCDM address.
- out_wen  out  1  TCDM wen.
- out_be  out  DATA_WIDTH/8  TCDM byte enables.
- out_data  out  DATA_WIDTH  TCDM write data.
- out_r_data  in  DATA_WIDTH  TCDM response data.
- out_r_valid  in  1  TCDM response valid.
- outstanding_o  out  $clog2(MAX_OUTSTANDING)+1  current FIFO occupancy.
- err_o  out  1  sticky: r_valid received with empty FIFO.

Behaviour:
- Clock and reset: one clock clk_i. Reset rst_ni is asynchronous, active-low.
- Reset values:
  - rr pointer = 0; FIFO empty; outstanding_o = 0; err_o = 0.
  - All in_gnt = 0 and in_r_valid = 0. out_req = 0.
- Protocol:
  - Requesters hold req and payload stable until granted.
  - A transaction transfers on a cycle with req && gnt.
  - Every transferred transaction, read or write, produces exactly one out_r_valid pulse, in order, ≥1 cycle after its grant.
- Selection (combinational):
  - sel = first asserted in_req scanning indices ptr, ptr+1, …, NB_REQ-1, 0, …, ptr-1 (wrap-around).
  - Payload of sel drives out_add/out_wen/out_be/out_data.
  - When nothing is selected, payload = 0.
- Request gating:
  - out_req = (any in_req) && !fifo_full.
  - in_gnt[sel] = out_gnt && out_req; all other in_gnt = 0. The grant is combinational, same cycle.
- Pointer update:
  - On a transfer, ptr <= (sel+1) mod NB_REQ.
  - Otherwise ptr holds, including when requests are present but stalled.
- Routing FIFO:
  - On a transfer, push sel.
  - On out_r_valid, pop the head. in_r_valid[head] = out_r_valid; in_r_data of every port = out_r_data. Response latency through the block is 0 cycles.
- Boundary conditions:
  - Push and pop in the same cycle: occupancy unchanged; both take effect.
  - Full: occupancy == MAX_OUTSTANDING ⇒ out_req = 0. A pop in that same cycle does NOT re-enable out_req; it re-enables the following cycle (no comb path r_valid→req).
  - out_r_valid while FIFO empty: no in_r_valid asserted, FIFO unchanged, err_o <= 1 until reset.
  - Reset mid-operation: FIFO and pointer are cleared immediately; responses arriving afterwards set err_o.
- outstanding_o = registered occupancy.

Test Plan:
- Single requester 1 issues 3 back-to-back reads to 0x100, 0x104, 0x108; out_gnt = 1; memory returns 0xA, 0xB, 0xC one cycle later → in_gnt[1] high 3 cycles; in_r_valid[1] pulses in the 3 cycles after, with data 0xA, 0xB, 0xC; other in_r_valid stay 0.
- All 3 requesters hold req with out_gnt = 1 → grant order 0, 1, 2, 0, 1, 2; each sees its own response in order.
- ptr = 2, only requesters 0 and 1 requesting → grant 0 first, then 1 (wrap-around).
- Memory withholds r_valid, MAX_OUTSTANDING = 4, requester 0 continuous → exactly 4 grants, then out_req = 0 and outstanding_o = 4.
  - Single r_valid then arrives → in_r_valid[0] in that cycle; out_req = 1 in the next cycle, not the same one.
- out_gnt = 0 for 5 cycles while requester 2 requests → in_gnt all 0, ptr unchanged, payload of requester 2 stable on out_*.
- out_r_valid with FIFO empty → no in_r_valid; err_o = 1 and remains 1.
  - Assert rst_ni low mid-burst with 2 outstanding → outstanding_o = 0 and err_o = 0 asynchronously.
